fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side adapter placed directly downstream of the synchronous FIFO (depth 16, 4-bit words). It pops the FIFO through its `rd_en`/`empty`/registered `dout` port and presents the words on a valid/ready stream. A 2-entry output buffer hides the FIFO's one-cycle read latency and sustains one word per cycle under continuous `m_ready`. The block also tracks the FIFO's write-over-read priority, so it never counts a read the FIFO ignored.

## Interface
- `DWIDTH`, 4: data width; must match the FIFO's `dwidth`.
- `CNTW`, 16: width of the delivered-word counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_wr_en`  in  1  snoop of the FIFO's `wr_en`, used for priority tracking.
- `fifo_dout`  in  DWIDTH  FIFO `dout`, valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DWIDTH  stream data (buffer head).
- `m_parity`  out  1  even parity of `m_data`. Present only with `FIFO_RD_STREAM_PARITY_EN`.
- `word_cnt`  out  CNTW  count of words transferred on the stream (`m_valid && m_ready`), wraps modulo 2^CNTW.

## Operation
- **Read accepted:** `rd_acc = fifo_rd_en && !fifo_empty && !(fifo_wr_en && !fifo_full)`. The FIFO gives a write priority over a read in the same cycle, so that read is dropped.
- **In flight:** `inflight` is a 1-bit register set to `rd_acc`. When `inflight` = 1, `fifo_dout` is captured into the buffer tail that cycle.
- **Pop:** `pop = m_valid && m_ready`.
- **Issue rule:** `fifo_rd_en = rst_n && !fifo_empty && (occ + inflight - pop) < 2`, where `occ` ∈ {0,1,2}.
  - This is combinational in `m_ready`, `fifo_empty` and state.
  - Never request more words than the buffer can hold.
- **Buffer:** 2-entry circular buffer with a 1-bit head pointer, a 1-bit tail pointer and a 2-bit `occ`.
  - Capture and pop in the same cycle: `occ` is unchanged and both pointers advance.
  - Capture with `occ` = 2 is impossible by construction. The assertion below flags it as an error.
- **Outputs:** `m_valid = (occ != 0)`; `m_data = buf[head]`.
- **Stream rules:**
  - `m_data` holds stable while `m_valid && !m_ready`.
  - `m_valid` never deasserts without a pop.
- **`word_cnt`:** +1 per pop, wraps `2^CNTW-1` → 0.
- **Reset** (`rst_n` = 0 at an edge):
  - `occ`, `head`, `tail`, `inflight`, `word_cnt` all go to 0.
  - Any read in flight is discarded and its data is not captured.
  - `fifo_rd_en` = 0 combinationally while `rst_n` = 0.
- **Embedded assertions (required):**
  - No capture when `occ` = 2.
  - `fifo_rd_en` is never high when `fifo_empty`.
  - `m_data` is stable while stalled.

## Timing
- **Reset values:** `m_valid` = 0, `m_data` = 0 (buffer cleared), `word_cnt` = 0, `fifo_rd_en` = 0, `m_parity` = 0.
- **Latency:** cycle N `rd_acc` → cycle N+1 `fifo_dout` captured → `m_valid` high from cycle N+2.
  - First word on an idle block: 2 cycles after `fifo_empty` falls, with `m_ready` = 1.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one pop per cycle after the first word.
- **Stall:** `m_ready` low. At most 2 words are buffered, then `fifo_rd_en` stays low until a pop.
- **Dropped read (write-priority cycle):** `inflight` stays 0 and no capture happens next cycle. The issue rule re-requests on the next cycle.

## Configuration
- `FIFO_RD_STREAM_PARITY_EN`
  - **Defined:** `m_parity` port exists and equals `^m_data`. It follows the buffer head with no extra latency.
  - **Undefined:** the port, its logic and its assertion are absent. All other behaviour is identical.

## Test plan
- **Reset/idle:** hold `rst_n` = 0 for 3 cycles with FIFO holding 5 words → `fifo_rd_en` = 0, `m_valid` = 0, `word_cnt` = 0. Release → `m_valid` rises 2 cycles after the first `fifo_rd_en`.
- **Streaming:** FIFO preloaded 0x1..0xF, `m_ready` = 1 → `m_data` sequence 0x1..0xF on 15 consecutive cycles, `word_cnt` = 15, then `m_valid` = 0.
- **Backpressure:** `m_ready` = 0 for 10 cycles with FIFO holding 6 → exactly 2 accepted reads, `m_valid` = 1, `m_data` = first word stable. Set `m_ready` = 1 → remaining words in order, no loss or duplication.
- **Write-priority drop:** assert `fifo_wr_en` (FIFO not full) in the cycle of `fifo_rd_en` → no capture next cycle, read re-issued, output order unchanged.
- **Reset mid-read:** pull `rst_n` low in the cycle after an accepted read → buffer empty, that word not delivered, `word_cnt` = 0.
- **Parity/wrap:** with `FIFO_RD_STREAM_PARITY_EN` and `CNTW` = 4, stream 17 words including 0x7 and 0x3 → `m_parity` = 1 for 0x7 and 0 for 0x3; `word_cnt` reads 1 after 17 words.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a synchronous FIFO and presents its words on a valid/ready stream.
// Define FIFO_RD_STREAM_PARITY_EN to add the m_parity output (even parity of m_data).
module fifo_rd_stream #(
  parameter int DWIDTH = 4,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_wr_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
`ifdef FIFO_RD_STREAM_PARITY_EN
  output logic              m_parity,
`endif
  output logic [CNTW-1:0]   word_cnt
);
  logic [DWIDTH-1:0] mem [2];
  logic head, tail, inflight, pop, rd_acc;
  logic [1:0] occ;
  logic [2:0] next_occ;
  assign pop = m_valid && m_ready;
  // occupancy after this cycle's capture and pop; a new read may only be issued if it will fit
  assign next_occ = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = rst_n && !fifo_empty && next_occ < 3'd2;
  // the FIFO services a same-cycle write instead of the read
  assign rd_acc = fifo_rd_en && !(fifo_wr_en && !fifo_full);
  assign m_valid = occ != 2'd0;
  assign m_data = mem[head];
`ifdef FIFO_RD_STREAM_PARITY_EN
  assign m_parity = ^m_data;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '{default: '0};
      head <= 1'b0;
      tail <= 1'b0;
      occ <= 2'd0;
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= rd_acc;
      occ <= next_occ[1:0];
      if (inflight) begin
        mem[tail] <= fifo_dout;
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(inflight && occ == 2'd2));
  a_rd_not_empty: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty));
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n) m_valid && !m_ready |=> $stable(m_data));
`ifdef FIFO_RD_STREAM_PARITY_EN
  a_parity: assert property (@(posedge clk) m_parity == ^m_data);
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives fifo_rd_stream from a behavioural 16-deep FIFO and checks the
// stream against a queue of written words.
module tb_fifo_rd_stream;
  localparam int DW = 4;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0, fifo_clr = 1;
  logic fifo_empty, fifo_full, fifo_rd_en, m_valid;
  logic fifo_wr_en = 0, m_ready = 0;
  logic [DW-1:0] fifo_dout, m_data, wr_data = '0;
  logic [CW-1:0] word_cnt;
`ifdef FIFO_RD_STREAM_PARITY_EN
  logic m_parity;
`endif
  logic [DW-1:0] fmem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;
  logic f_wa, f_ra;
  int acc_reads;
  int tests = 0, fails = 0, exp_cnt = 0;
  logic [DW-1:0] exp_q [$];

  fifo_rd_stream #(.DWIDTH(DW), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef FIFO_RD_STREAM_PARITY_EN
    .m_parity(m_parity),
`endif
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = fcnt == 5'd0;
  assign fifo_full = fcnt == 5'd16;
  assign f_wa = fifo_wr_en && !fifo_full;
  assign f_ra = fifo_rd_en && !fifo_empty && !f_wa;
  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= '0; rp <= '0; fcnt <= '0; fifo_dout <= '0; acc_reads <= 0;
    end else begin
      if (f_wa) begin fmem[wp] <= wr_data; wp <= wp + 4'd1; end
      if (f_ra) begin fifo_dout <= fmem[rp]; rp <= rp + 4'd1; acc_reads <= acc_reads + 1; end
      fcnt <= fcnt + {4'b0, f_wa} - {4'b0, f_ra};
    end
  end

  task automatic drive(input logic r, input logic rdy, input logic wr, input logic [DW-1:0] d);
    @(posedge clk); #1;
    rst_n = r; m_ready = rdy; wr_data = d;
    fifo_wr_en = wr && !fifo_full;
    if (wr && !fifo_full) exp_q.push_back(d);
    @(negedge clk);
  endtask

  // clears FIFO, holds the DUT in reset and writes n words (mode 1: 1..n, mode 2: random with 7 and 3)
  task automatic load(input int n, input int mode);
    logic [DW-1:0] d;
    exp_q.delete(); exp_cnt = 0;
    @(posedge clk); #1; fifo_clr = 1; rst_n = 0; fifo_wr_en = 0; m_ready = 0;
    @(posedge clk); #1; fifo_clr = 0;
    for (int i = 0; i < n; i++) begin
      d = mode == 1 ? DW'(i + 1) : DW'($urandom);
      if (mode == 2 && i == 5) d = 4'h7;
      if (mode == 2 && i == 9) d = 4'h3;
      drive(0, 0, 1, d);
    end
    drive(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    load(5, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0);
      tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
      tests++; if (word_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt); end
      tests++; if (m_data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", m_data); end
`ifdef FIFO_RD_STREAM_PARITY_EN
      tests++; if (m_parity !== 1'b0) begin fails++; $display("FAIL reset_parity: got %b expected 0", m_parity); end
`endif
    end
    drive(1, 1, 0, '0);
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL release_rd_en: got %b expected 1", fifo_rd_en); end
    drive(1, 1, 0, '0);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL latency_early: got %b expected 0", m_valid); end
    drive(1, 1, 0, '0);
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL latency_first: got %b expected 1", m_valid); end
    for (int i = 0; i < 20; i++) begin
      if (i > 0) drive(1, 1, 0, '0);
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
        exp_cnt++; tests++;
        if (m_data !== e) begin fails++; $display("FAIL reset_stream: got %h expected %h", m_data, e); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL reset_left: got %0d words undelivered expected 0", exp_q.size()); end
    tests++; if (word_cnt !== CW'(5)) begin fails++; $display("FAIL reset_total: got %0d expected 5", word_cnt); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_idle: got %b expected 0", m_valid); end
  endtask

  task automatic test_streaming();
    load(15, 1);
    drive(1, 1, 0, '0);
    for (int i = 0; i < 5 && !m_valid; i++) drive(1, 1, 0, '0);
    for (int i = 1; i <= 15; i++) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== DW'(i)) begin
        fails++; $display("FAIL stream_seq: got valid %b data %h expected valid 1 data %h", m_valid, m_data, DW'(i));
      end
      if (i < 15) drive(1, 1, 0, '0);
    end
    drive(1, 1, 0, '0);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL stream_end: got %b expected 0", m_valid); end
    tests++; if (word_cnt !== CW'(15)) begin fails++; $display("FAIL stream_cnt: got %0d expected 15", word_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e;
    load(6, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, '0);
      if (i >= 2) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
          fails++; $display("FAIL bp_hold: got valid %b data %h expected valid 1 data %h", m_valid, m_data, exp_q[0]);
        end
      end
    end
    tests++; if (acc_reads != 2) begin fails++; $display("FAIL bp_reads: got %0d expected 2", acc_reads); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en: got %b expected 0", fifo_rd_en); end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, '0);
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
        exp_cnt++; tests++;
        if (m_data !== e) begin fails++; $display("FAIL bp_stream: got %h expected %h", m_data, e); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_left: got %0d words undelivered expected 0", exp_q.size()); end
    tests++; if (word_cnt !== CW'(6)) begin fails++; $display("FAIL bp_cnt: got %0d expected 6", word_cnt); end
  endtask

  task automatic test_write_priority();
    logic [DW-1:0] e;
    load(4, 0);
    drive(1, 1, 1, DW'($urandom));
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL wp_request: got %b expected 1", fifo_rd_en); end
    drive(1, 1, 0, '0);
    tests++; if (acc_reads != 0) begin fails++; $display("FAIL wp_dropped: got %0d reads expected 0", acc_reads); end
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL wp_reissue: got %b expected 1", fifo_rd_en); end
    drive(1, 1, 0, '0);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL wp_no_capture: got %b expected 0", m_valid); end
    for (int i = 0; i < 50; i++) begin
      drive(1, 1, i < 25 && $urandom_range(0, 2) == 0, DW'($urandom));
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
        exp_cnt++; tests++;
        if (m_data !== e) begin fails++; $display("FAIL wp_stream: got %h expected %h", m_data, e); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL wp_left: got %0d words undelivered expected 0", exp_q.size()); end
    tests++; if (word_cnt !== CW'(exp_cnt)) begin fails++; $display("FAIL wp_cnt: got %0d expected %0d", word_cnt, CW'(exp_cnt)); end
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] e;
    load(5, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, '0);
    drive(1, 1, 0, '0);
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL mid_issue: got %b expected 1", fifo_rd_en); end
    if (m_valid && m_ready) begin
      if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
      exp_cnt++; tests++;
      if (m_data !== e) begin fails++; $display("FAIL mid_first: got %h expected %h", m_data, e); end
    end
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", m_valid); end
    tests++; if (word_cnt !== '0) begin fails++; $display("FAIL mid_cnt: got %0d expected 0", word_cnt); end
    // words popped from the FIFO but not delivered before reset are lost
    repeat (acc_reads - exp_cnt) if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, '0);
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
        exp_cnt++; tests++;
        if (m_data !== e) begin fails++; $display("FAIL mid_stream: got %h expected %h", m_data, e); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mid_left: got %0d words undelivered expected 0", exp_q.size()); end
    tests++; if (word_cnt !== CW'(2)) begin fails++; $display("FAIL mid_total: got %0d expected 2", word_cnt); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e, prev_data;
    logic prev_stall;
    load(0, 0);
    prev_stall = 0; prev_data = '0;
    for (int i = 0; i < 300; i++) begin
      drive(1, i >= 250 || $urandom_range(0, 9) < 7, i < 250 && $urandom_range(0, 9) < 4, DW'($urandom));
      if (prev_stall) begin
        tests++;
        if (m_data !== prev_data) begin fails++; $display("FAIL rand_stall: got %h expected %h", m_data, prev_data); end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
        exp_cnt++; tests++;
        if (m_data !== e) begin fails++; $display("FAIL rand_stream: got %h expected %h", m_data, e); end
`ifdef FIFO_RD_STREAM_PARITY_EN
        tests++; if (m_parity !== ^e) begin fails++; $display("FAIL rand_parity: got %b expected %b", m_parity, ^e); end
`endif
      end
      prev_stall = m_valid && !m_ready; prev_data = m_data;
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_left: got %0d words undelivered expected 0", exp_q.size()); end
    tests++; if (word_cnt !== CW'(exp_cnt)) begin fails++; $display("FAIL rand_cnt: got %0d expected %0d", word_cnt, CW'(exp_cnt)); end
  endtask

  task automatic test_wrap_parity();
    logic [DW-1:0] e;
    load(16, 2);
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, i == 6, DW'($urandom));
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
        exp_cnt++; tests++;
        if (m_data !== e) begin fails++; $display("FAIL wrap_stream: got %h expected %h", m_data, e); end
`ifdef FIFO_RD_STREAM_PARITY_EN
        tests++; if (m_parity !== ^e) begin fails++; $display("FAIL wrap_parity: got %b expected %b for %h", m_parity, ^e, e); end
`endif
      end
    end
    tests++; if (exp_cnt != 17) begin fails++; $display("FAIL wrap_words: got %0d expected 17", exp_cnt); end
    tests++; if (word_cnt !== CW'(1)) begin fails++; $display("FAIL wrap_cnt: got %0d expected 1", word_cnt); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_write_priority();
    test_reset_mid_read();
    test_random();
    test_wrap_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
